// File: rtl/truxton2_pkg.sv
// Shared definitions for the Truxton II graphics fetch path: requester indices,
// address width and the arbiter FSM encoding.
package truxton2_pkg;

    localparam int unsigned REQ_SPR  = 0;
    localparam int unsigned REQ_SCR0 = 1;
    localparam int unsigned REQ_SCR1 = 2;
    localparam int unsigned REQ_SCR2 = 3;
    localparam int unsigned NREQ     = 4;
    localparam int unsigned GFX_AW   = 22;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StData0 = 2'd2,
        StData1 = 2'd3
    } gfx_state_e;

endpackage

// File: rtl/truxton2_rr_pick.sv
// Combinational winner select over four pending requesters, either round-robin
// starting at a pointer or fixed priority with index 0 highest.
module truxton2_rr_pick
    import truxton2_pkg::*;
(
    input  logic [NREQ-1:0] i_pend,
    input  logic [1:0]      i_ptr,
    input  logic            i_rr_en,
    output logic [1:0]      o_win,
    output logic            o_vld
);

    logic [1:0] w_base;
    logic [1:0] w_idx;

    // Scan from the farthest offset down so the nearest pending index is written last.
    always_comb begin
        w_base = i_rr_en ? i_ptr : 2'd0;
        w_idx  = 2'd0;
        o_win  = 2'd0;
        o_vld  = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = w_base + 2'(k);
            if (i_pend[w_idx]) begin
                o_win = w_idx;
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/truxton2_gfx_arbiter.sv
// Shares one SDRAM bank read port among the sprite and three scroll fetchers,
// assembling 32-bit words from two-word bursts and caching one line per requester.
module truxton2_gfx_arbiter
    import truxton2_pkg::*;
#(
    parameter int unsigned AW      = GFX_AW,
    parameter bit          RR_EN   = 1'b1,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NREQ-1:0]      i_req_cs,
    input  logic [NREQ*AW-1:0]   i_req_addr,
    output logic [NREQ-1:0]      o_req_ok,
    output logic [NREQ*32-1:0]   o_req_dout,
    output logic [AW-1:0]        o_ba_addr,
    output logic                 o_ba_rd,
    input  logic                 i_ba_ack,
    input  logic                 i_ba_dst,
    input  logic                 i_ba_rdy,
    input  logic [15:0]          i_data_read,
    output logic                 o_busy
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    gfx_state_e      r_state;
    logic [1:0]      r_gnt;
    logic [1:0]      r_ptr;
    logic [AW-1:0]   r_addr_l;
    logic [15:0]     r_lo;
    logic [CW-1:0]   r_cnt;
    logic            r_ba_rd;
    logic [AW-1:0]   r_ba_addr;
    logic            r_busy;
    logic [NREQ-1:0] r_vld;
    logic [NREQ-1:0] r_ok;
    logic [AW-1:0]   r_tag  [NREQ];
    logic [31:0]     r_data [NREQ];

    logic [AW-1:0]   w_addr [NREQ];
    logic [NREQ-1:0] w_hit;
    logic [NREQ-1:0] w_pend;
    logic [NREQ-1:0] w_fill;
    logic [NREQ-1:0] w_ok_d;
    logic [1:0]      w_win;
    logic            w_win_vld;
    logic            w_done;
    logic            w_tmo;

    assign w_done = (r_state == StData1) && i_ba_rdy;
    assign w_tmo  = (r_cnt == CW'(TIMEOUT - 1));

    // A line being filled this cycle counts as a hit so OK rises right after BA_RDY.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_addr[i] = i_req_addr[i*AW +: AW];
            w_hit[i]  = r_vld[i] && (r_tag[i] == w_addr[i]);
            w_pend[i] = i_req_cs[i] && !w_hit[i];
            w_fill[i] = w_done && (r_gnt == 2'(i));
            w_ok_d[i] = i_req_cs[i] && (w_fill[i] ? (w_addr[i] == r_addr_l) : w_hit[i]);
        end
    end

    truxton2_rr_pick u_pick (
        .i_pend  (w_pend),
        .i_ptr   (r_ptr),
        .i_rr_en (RR_EN),
        .o_win   (w_win),
        .o_vld   (w_win_vld)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_gnt     <= 2'd0;
            r_ptr     <= 2'd0;
            r_addr_l  <= '0;
            r_lo      <= 16'd0;
            r_cnt     <= '0;
            r_ba_rd   <= 1'b0;
            r_ba_addr <= '0;
            r_busy    <= 1'b0;
            r_vld     <= '0;
            r_ok      <= '0;
            for (int i = 0; i < NREQ; i++) begin
                r_tag[i]  <= '0;
                r_data[i] <= 32'd0;
            end
        end else begin
            r_ok <= w_ok_d;
            if (r_state != StIdle) begin
                r_cnt <= r_cnt + 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_win_vld) begin
                        r_gnt     <= w_win;
                        r_addr_l  <= w_addr[w_win];
                        r_ba_addr <= {w_addr[w_win][AW-2:0], 1'b0};
                        r_ba_rd   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= StReq;
                    end
                end
                StReq: begin
                    if (i_ba_ack) begin
                        r_ba_rd <= 1'b0;
                        if (i_ba_dst) begin
                            r_lo    <= i_data_read;
                            r_state <= StData1;
                        end else begin
                            r_state <= StData0;
                        end
                    end else if (w_tmo) begin
                        r_ba_rd <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                StData0: begin
                    if (i_ba_dst) begin
                        r_lo    <= i_data_read;
                        r_state <= StData1;
                    end else if (w_tmo) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                StData1: begin
                    if (i_ba_rdy) begin
                        r_data[r_gnt] <= {i_data_read, r_lo};
                        r_tag[r_gnt]  <= r_addr_l;
                        r_vld[r_gnt]  <= 1'b1;
                        r_ptr         <= r_gnt + 2'd1;
                        r_busy        <= 1'b0;
                        r_state       <= StIdle;
                    end else if (w_tmo) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        o_req_dout = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_req_dout[i*32 +: 32] = r_data[i];
        end
    end

    assign o_req_ok  = r_ok;
    assign o_ba_addr = r_ba_addr;
    assign o_ba_rd   = r_ba_rd;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_truxton2_gfx_arbiter.sv
// Directed bench: instance 0 is round-robin, instance 1 fixed priority, both with a short timeout.
module tb_truxton2_gfx_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   cs      [2];
    logic [87:0]  addr    [2];
    logic [3:0]   ok      [2];
    logic [127:0] dout    [2];
    logic [21:0]  ba_addr [2];
    logic         ba_rd   [2];
    logic         ba_ack  [2];
    logic         ba_dst  [2];
    logic         ba_rdy  [2];
    logic [15:0]  dr      [2];
    logic         busy    [2];

    int n_checks = 0;
    int n_errors = 0;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        truxton2_gfx_arbiter #(
            .AW      (22),
            .RR_EN   (d == 0),
            .TIMEOUT (15)
        ) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_req_cs    (cs[d]),
            .i_req_addr  (addr[d]),
            .o_req_ok    (ok[d]),
            .o_req_dout  (dout[d]),
            .o_ba_addr   (ba_addr[d]),
            .o_ba_rd     (ba_rd[d]),
            .i_ba_ack    (ba_ack[d]),
            .i_ba_dst    (ba_dst[d]),
            .i_ba_rdy    (ba_rdy[d]),
            .i_data_read (dr[d]),
            .o_busy      (busy[d])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_rd(input int d, input string tag);
        int n;
        n = 0;
        while (ba_rd[d] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_eq(tag, ba_rd[d], 1'b1);
    endtask

    // Bank side of one fetch: ACK, low half, high half, each one cycle apart.
    task automatic serve(input int d, input logic [15:0] lo, input logic [15:0] hi,
                         output logic [21:0] a);
        wait_rd(d, "serve_rd");
        a = ba_addr[d];
        ba_ack[d] = 1'b1;
        tick();
        ba_ack[d] = 1'b0;
        ba_dst[d] = 1'b1;
        dr[d]     = lo;
        tick();
        ba_dst[d] = 1'b0;
        ba_rdy[d] = 1'b1;
        dr[d]     = hi;
        tick();
        ba_rdy[d] = 1'b0;
        dr[d]     = 16'd0;
    endtask

    // order holds the expected grant sequence, first grant in bits [1:0].
    task automatic rr_round(input int d, input logic [21:0] base, input logic [7:0] order,
                            input string tag);
        logic [21:0] a;
        logic [21:0] want;
        for (int i = 0; i < 4; i++) addr[d][i*22 +: 22] = base + 22'(i);
        cs[d] = 4'hF;
        for (int k = 0; k < 4; k++) begin
            serve(d, 16'h1000 + 16'(k), 16'h2000 + 16'(k), a);
            want = (base + 22'(order[2*k +: 2])) << 1;
            check_eq($sformatf("%s_grant%0d", tag, k), a, want);
        end
        check_eq({tag, "_ok"}, ok[d], 4'hF);
        cs[d] = 4'h0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [21:0] a;
        int          n;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            cs[d] = 4'h0; addr[d] = '0; ba_ack[d] = 1'b0;
            ba_dst[d] = 1'b0; ba_rdy[d] = 1'b0; dr[d] = 16'd0;
        end
        tick();
        tick();
        check_eq("rst_ok", ok[0], 4'h0);
        check_eq("rst_dout", dout[0], 128'd0);
        check_eq("rst_baaddr", ba_addr[0], 22'd0);
        check_eq("rst_bard", ba_rd[0], 1'b0);
        check_eq("rst_busy", busy[0], 1'b0);
        rst = 1'b0;
        tick();

        // Round-robin from ptr 0, then ptr 2 after a lone req1 fetch.
        rr_round(0, 22'h100, 8'b11_10_01_00, "rr_a");
        cs[0] = 4'b0010;
        addr[0][22 +: 22] = 22'h180;
        serve(0, 16'h0, 16'h0, a);
        check_eq("rr_single1", a, 22'h300);
        cs[0] = 4'h0;
        tick();
        rr_round(0, 22'h200, 8'b01_00_11_10, "rr_b");

        // Fixed priority ignores history.
        rr_round(1, 22'h100, 8'b11_10_01_00, "fp_a");
        cs[1] = 4'b0010;
        addr[1][22 +: 22] = 22'h180;
        serve(1, 16'h0, 16'h0, a);
        cs[1] = 4'h0;
        tick();
        rr_round(1, 22'h200, 8'b11_10_01_00, "fp_b");

        // Single fetch with exact bank timing.
        cs[0] = 4'b0001;
        addr[0][21:0] = 22'h00123;
        tick();
        check_eq("sf_rd", ba_rd[0], 1'b1);
        check_eq("sf_baaddr", ba_addr[0], 22'h000246);
        check_eq("sf_busy", busy[0], 1'b1);
        tick();
        ba_ack[0] = 1'b1;
        tick();
        ba_ack[0] = 1'b0;
        check_eq("sf_rd_drop", ba_rd[0], 1'b0);
        tick();
        ba_dst[0] = 1'b1;
        dr[0] = 16'hBEEF;
        tick();
        ba_dst[0] = 1'b0;
        ba_rdy[0] = 1'b1;
        dr[0] = 16'hDEAD;
        check_eq("sf_ok_early", ok[0][0], 1'b0);
        tick();
        ba_rdy[0] = 1'b0;
        dr[0] = 16'h0;
        check_eq("sf_ok", ok[0][0], 1'b1);
        check_eq("sf_dout", dout[0][31:0], 32'hDEADBEEF);
        check_eq("sf_idle", busy[0], 1'b0);

        // Hit: toggle CS with the address held.
        cs[0] = 4'b0000;
        tick();
        check_eq("hit_ok_off", ok[0][0], 1'b0);
        cs[0] = 4'b0001;
        tick();
        check_eq("hit_ok", ok[0][0], 1'b1);
        check_eq("hit_no_rd", ba_rd[0], 1'b0);
        check_eq("hit_no_busy", busy[0], 1'b0);
        cs[0] = 4'b0000;
        tick();

        // Address change while the first burst is in DATA0.
        cs[0] = 4'b0010;
        addr[0][22 +: 22] = 22'h10;
        wait_rd(0, "ac_rd");
        check_eq("ac_baaddr0", ba_addr[0], 22'h000020);
        ba_ack[0] = 1'b1;
        tick();
        ba_ack[0] = 1'b0;
        addr[0][22 +: 22] = 22'h11;
        tick();
        ba_dst[0] = 1'b1;
        dr[0] = 16'h1111;
        tick();
        ba_dst[0] = 1'b0;
        ba_rdy[0] = 1'b1;
        dr[0] = 16'h2222;
        tick();
        ba_rdy[0] = 1'b0;
        dr[0] = 16'h0;
        check_eq("ac_ok_low", ok[0][1], 1'b0);
        check_eq("ac_dout_old", dout[0][63:32], 32'h22221111);
        serve(0, 16'h3333, 16'h4444, a);
        check_eq("ac_baaddr1", a, 22'h000022);
        check_eq("ac_ok", ok[0][1], 1'b1);
        check_eq("ac_dout_new", dout[0][63:32], 32'h44443333);
        cs[0] = 4'b0000;
        tick();

        // Timeout: no ACK, so BA_RD holds for 15 cycles then the same requester is re-granted.
        cs[0] = 4'b0100;
        addr[0][44 +: 22] = 22'h3A5;
        wait_rd(0, "to_rd");
        n = 0;
        while (ba_rd[0] === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        check_eq("to_len", n, 15);
        check_eq("to_busy_low", busy[0], 1'b0);
        tick();
        check_eq("to_regrant_rd", ba_rd[0], 1'b1);
        check_eq("to_regrant_busy", busy[0], 1'b1);
        check_eq("to_regrant_addr", ba_addr[0], 22'h00074A);
        serve(0, 16'h5A5A, 16'hA5A5, a);
        check_eq("to_ok", ok[0][2], 1'b1);
        check_eq("to_dout", dout[0][95:64], 32'hA5A55A5A);
        cs[0] = 4'b0000;
        tick();

        // Reset in DATA1; a stray BA_RDY afterwards must store nothing.
        cs[0] = 4'b1000;
        addr[0][66 +: 22] = 22'h77;
        wait_rd(0, "rm_rd");
        ba_ack[0] = 1'b1;
        tick();
        ba_ack[0] = 1'b0;
        ba_dst[0] = 1'b1;
        dr[0] = 16'h5555;
        tick();
        ba_dst[0] = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rm_rd_low", ba_rd[0], 1'b0);
        check_eq("rm_busy_low", busy[0], 1'b0);
        check_eq("rm_dout_clr", dout[0], 128'd0);
        check_eq("rm_ok_clr", ok[0], 4'h0);
        check_eq("rm_baaddr_clr", ba_addr[0], 22'd0);
        tick();
        rst = 1'b0;
        cs[0] = 4'b0000;
        ba_rdy[0] = 1'b1;
        dr[0] = 16'h6666;
        tick();
        ba_rdy[0] = 1'b0;
        dr[0] = 16'h0;
        check_eq("rm_stray_dout", dout[0], 128'd0);
        check_eq("rm_stray_busy", busy[0], 1'b0);
        cs[0] = 4'b1000;
        tick();
        check_eq("rm_no_line_ok", ok[0][3], 1'b0);
        check_eq("rm_refetch_rd", ba_rd[0], 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
